div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Shares the single iterative divider between the two issue slots of the EX stage: the main pipe (slot 0, older instruction) and the sub pipe (slot 1, younger instruction).
- Captures DIV/DIVU requests from both slots and launches them on the divider in program order.
- Holds the pipeline via stall requests until every pending quotient/remainder is ready, then presents the results to each slot's HI/LO write path.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W wide.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-low (0 = reset).
- flush_i  in  1  pipeline flush (exception/eret); kills all in-flight division work.
- stall_i  in  1  downstream stall; EX contents held this cycle.
- req0_i  in  1  slot 0 holds DIV/DIVU.
- signed0_i  in  1  slot 0 is DIV (1) or DIVU (0).
- opa0_i  in  DATA_W  slot 0 dividend.
- opb0_i  in  DATA_W  slot 0 divisor.
- req1_i, signed1_i, opa1_i, opb1_i  in  1/1/DATA_W/DATA_W  same fields for slot 1.
- div_start_o  out  1  one-cycle launch pulse to the divider.
- div_signed_o  out  1  signedness of the launched operation.
- div_opdata1_o  out  DATA_W  dividend to the divider.
- div_opdata2_o  out  DATA_W  divisor to the divider.
- div_annul_o  out  1  one-cycle abort pulse to the divider.
- div_result_i  in  2*DATA_W  {remainder, quotient}.
- div_ready_i  in  1  one-cycle pulse: div_result_i is valid.
- stallreq0_o  out  1  stall request for slot 0.
- stallreq1_o  out  1  stall request for slot 1.
- res0_o  out  2*DATA_W  slot 0 {hi, lo}.
- res1_o  out  2*DATA_W  slot 1 {hi, lo}.
- valid0_o  out  1  res0_o is valid; slot 0 may write HI/LO.
- valid1_o  out  1  res1_o is valid; slot 1 may write HI/LO.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State = IDLE; all outputs 0; result registers 0; done flags cleared.
- States: IDLE, RUN0, RUN1, DONE.
- IDLE:
  - Latch req0/req1 into pending flags and latch the operands of each requesting slot.
  - If no request, stay IDLE with stallreq = 0.
  - If any request, assert both stallreq outputs combinationally in the same cycle (the whole bundle stalls).
  - If req0, go to RUN0; else if req1, go to RUN1.
- Launch:
  - On entering RUN0/RUN1, div_start_o = 1 for exactly one cycle, with div_opdata1/2 and div_signed driven from the latched operands.
  - These outputs stay stable until div_ready_i arrives.
- Divisor zero:
  - The divider is not launched.
  - The result register for that slot is loaded with {opa, 0}, and the slot is marked done in the entry cycle.
- RUN0 on div_ready_i:
  - Capture div_result_i into res0.
  - If slot 1 is pending, go to RUN1 and launch it next cycle; no idle bubble beyond that one cycle.
  - Otherwise go to DONE.
- RUN1 on div_ready_i: capture into res1, then go to DONE.
- Both stallreq outputs stay 1 throughout RUN0/RUN1 and the IDLE cycle that accepted the requests.
- DONE:
  - stallreq outputs = 0.
  - validN_o = 1 for each slot that was pending.
  - req inputs are ignored, because the same instructions are still visible.
  - If stall_i = 1, stay in DONE with outputs held.
  - Otherwise clear the pending flags and go to IDLE next cycle.
- flush_i = 1 (highest priority after reset):
  - If in RUN0/RUN1 with the divider launched and not yet ready, div_annul_o = 1 for one cycle.
  - Next state is IDLE with pending/done flags cleared.
  - stallreq and valid outputs are 0 in the flush cycle.
  - A div_ready_i arriving in the flush cycle is discarded.
- Stray div_ready_i in IDLE or DONE is ignored.
- Latency:
  - Single request: divider latency + 2 cycles (accept, result capture).
  - Dual request: two divider latencies + 3 cycles.
- Reset mid-operation: state returns to IDLE; div_annul_o stays 0 because the divider is reset by the same rst.

Decomposition:
- Shared defines, next to the existing ones:
  - state encodings DS_IDLE, DS_RUN0, DS_RUN1, DS_DONE;
  - DivStart/DivStop;
  - DivResultReady/DivResultNotReady;
  - a 2*DATA_W DoubleRegBus.
- No sub-module. The per-slot operand/result capture is a generate loop of two identical register groups inside div_sched.

Test Plan:
- Slot 0 only, DIV of -7 by 2 (signed), with a stub divider of 4-cycle latency:
  - div_start_o pulses once with operands 0xFFFFFFF9 / 0x2.
  - Stall holds for 6 cycles.
  - res0_o = {0xFFFFFFFF, 0xFFFFFFFD} and valid0_o = 1 for one cycle.
- Both slots, DIVU 100/7 and DIVU 9/3:
  - Two start pulses, slot 0 operands first.
  - res0 = {2, 14}, res1 = {0, 3}; both valid in the same DONE cycle.
  - Stall lasts 4+4+3 cycles.
- Slot 1 only with divisor 0:
  - No div_start_o.
  - DONE is reached within 2 cycles with res1 = {opa1, 0}.
- flush_i asserted 2 cycles after launch:
  - div_annul_o pulses once; state returns to IDLE; no valid.
  - A subsequent ready pulse from the stub is ignored.
- stall_i held 3 cycles while in DONE:
  - valid and results are stable for 3+1 cycles.
  - No relaunch occurs while req inputs are still high.
- rst = 0 mid-RUN0: next cycle all outputs are 0 and the state is IDLE; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared definitions for the dual-slot divider scheduler: FSM encoding,
// divider handshake levels and the double-width HI/LO result bus.
package div_sched_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_RUN0 = 2'd1,
        DS_RUN1 = 2'd2,
        DS_DONE = 2'd3
    } ds_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef logic [2*DIV_DATA_W-1:0] DoubleRegBus;

endpackage

// File: rtl/div_sched.sv
// Shares one iterative divider between the two EX issue slots: requests are
// launched oldest-first, the bundle stalls until all results are back.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                stall_i,
    input  logic                req0_i,
    input  logic                signed0_i,
    input  logic [DATA_W-1:0]   opa0_i,
    input  logic [DATA_W-1:0]   opb0_i,
    input  logic                req1_i,
    input  logic                signed1_i,
    input  logic [DATA_W-1:0]   opa1_i,
    input  logic [DATA_W-1:0]   opb1_i,
    output logic                div_start_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_opdata1_o,
    output logic [DATA_W-1:0]   div_opdata2_o,
    output logic                div_annul_o,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                stallreq0_o,
    output logic                stallreq1_o,
    output logic [2*DATA_W-1:0] res0_o,
    output logic [2*DATA_W-1:0] res1_o,
    output logic                valid0_o,
    output logic                valid1_o
);

    localparam int RES_W = 2 * DATA_W;

    // Division by zero bypasses the divider: remainder = dividend, quotient = 0.
    function automatic logic [RES_W-1:0] zero_div_result(input logic [DATA_W-1:0] opa);
        return {opa, {DATA_W{1'b0}}};
    endfunction

    ds_state_e         state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0]        done_q, done_d;
    logic              launched_q, launched_d;
    logic [1:0]        req_v, lat_en, res_en;
    logic [DATA_W-1:0] opa_w [2];
    logic [DATA_W-1:0] opb_w [2];
    logic              sgn_w [2];
    logic [RES_W-1:0]  res_w [2];
    logic [RES_W-1:0]  res_val;
    logic              in_run, cur, cur_zero, finish, stall_all;

    assign req_v    = {req1_i, req0_i};
    assign in_run   = (state_q == DS_RUN0) || (state_q == DS_RUN1);
    assign cur      = (state_q == DS_RUN1);
    assign cur_zero = (opb_w[cur] == '0);
    assign finish   = in_run && (cur_zero || (launched_q && (div_ready_i == DivResultReady)));
    assign res_val  = cur_zero ? zero_div_result(opa_w[cur]) : div_result_i;

    assign div_start_o   = (rst && !flush_i && in_run && !launched_q && !cur_zero) ? DivStart : DivStop;
    assign div_annul_o   = rst && flush_i && in_run && launched_q && (div_ready_i == DivResultNotReady);
    assign div_signed_o  = in_run ? sgn_w[cur] : 1'b0;
    assign div_opdata1_o = in_run ? opa_w[cur] : '0;
    assign div_opdata2_o = in_run ? opb_w[cur] : '0;

    assign stall_all   = !flush_i && ((state_q == DS_IDLE) ? (|req_v) : in_run);
    assign stallreq0_o = stall_all;
    assign stallreq1_o = stall_all;
    assign valid0_o    = !flush_i && (state_q == DS_DONE) && pend_q[0] && done_q[0];
    assign valid1_o    = !flush_i && (state_q == DS_DONE) && pend_q[1] && done_q[1];
    assign res0_o      = res_w[0];
    assign res1_o      = res_w[1];

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        done_d     = done_q;
        launched_d = launched_q;
        lat_en     = '0;
        res_en     = '0;
        if (flush_i) begin
            state_d    = DS_IDLE;
            pend_d     = '0;
            done_d     = '0;
            launched_d = 1'b0;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    if (|req_v) begin
                        lat_en  = req_v;
                        pend_d  = req_v;
                        done_d  = '0;
                        state_d = req0_i ? DS_RUN0 : DS_RUN1;
                    end
                end
                DS_RUN0, DS_RUN1: begin
                    if (div_start_o == DivStart) launched_d = 1'b1;
                    if (finish) begin
                        res_en[cur] = 1'b1;
                        done_d[cur] = 1'b1;
                        launched_d  = 1'b0;
                        state_d     = (state_q == DS_RUN0 && pend_q[1]) ? DS_RUN1 : DS_DONE;
                    end
                end
                DS_DONE: begin
                    // The same instructions stay visible while held, so requests are not re-sampled here.
                    if (!stall_i) begin
                        state_d = DS_IDLE;
                        pend_d  = '0;
                        done_d  = '0;
                    end
                end
                default: state_d = DS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DS_IDLE;
            pend_q     <= '0;
            done_q     <= '0;
            launched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            launched_q <= launched_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_slot
        logic [DATA_W-1:0] opa_q, opb_q, opa_sel, opb_sel;
        logic              sgn_q, sgn_sel;
        logic [RES_W-1:0]  res_q;

        assign opa_sel = (g == 0) ? opa0_i    : opa1_i;
        assign opb_sel = (g == 0) ? opb0_i    : opb1_i;
        assign sgn_sel = (g == 0) ? signed0_i : signed1_i;

        always_ff @(posedge clk) begin
            if (lat_en[g]) begin
                opa_q <= opa_sel;
                opb_q <= opb_sel;
                sgn_q <= sgn_sel;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) res_q <= '0;
            else if (res_en[g]) res_q <= res_val;
        end

        assign opa_w[g] = opa_q;
        assign opb_w[g] = opb_q;
        assign sgn_w[g] = sgn_q;
        assign res_w[g] = res_q;
    end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: a 4-cycle stub divider answers launches, and a
// scoreboard queue holds the HI/LO results each scenario expects.
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int STUB_LAT = 4;

    logic        clk = 1'b0;
    logic        rst, flush_i, stall_i;
    logic        req0_i, signed0_i, req1_i, signed1_i;
    logic [31:0] opa0_i, opb0_i, opa1_i, opb1_i;
    logic        div_start_o, div_signed_o, div_annul_o, div_ready_i;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    DoubleRegBus div_result_i, res0_o, res1_o;
    logic        stallreq0_o, stallreq1_o, valid0_o, valid1_o;

    typedef struct {
        int          slot;
        DoubleRegBus res;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    div_sched #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .req0_i(req0_i), .signed0_i(signed0_i), .opa0_i(opa0_i), .opb0_i(opb0_i),
        .req1_i(req1_i), .signed1_i(signed1_i), .opa1_i(opa1_i), .opb1_i(opb1_i),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
        .div_annul_o(div_annul_o), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .stallreq0_o(stallreq0_o), .stallreq1_o(stallreq1_o),
        .res0_o(res0_o), .res1_o(res1_o), .valid0_o(valid0_o), .valid1_o(valid1_o)
    );

    always #5 clk = ~clk;

    function automatic DoubleRegBus model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Stub divider: ready pulses STUB_LAT cycles after the start cycle; annul is ignored.
    int          stub_cnt;
    DoubleRegBus stub_res;
    always @(posedge clk) begin
        div_ready_i <= 1'b0;
        if (!rst) begin
            stub_cnt <= 0;
        end else if (div_start_o) begin
            stub_cnt <= STUB_LAT - 1;
            stub_res <= model_div(div_signed_o, div_opdata1_o, div_opdata2_o);
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                div_ready_i  <= 1'b1;
                div_result_i <= stub_res;
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic s, input logic [31:0] a, input logic [31:0] b);
        req0_i = 1'b1; signed0_i = s; opa0_i = a; opb0_i = b;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        to_drive();
        to_drive();
        @(negedge clk);
        n_vec++;
        if ({div_start_o, div_annul_o, stallreq0_o, stallreq1_o, valid0_o, valid1_o, res0_o, res1_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got start=%b annul=%b stall=%b%b valid=%b%b res0=%h res1=%h want all 0",
                     div_start_o, div_annul_o, stallreq0_o, stallreq1_o, valid0_o, valid1_o, res0_o, res1_o);
        end
        to_drive();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({stallreq0_o, valid0_o, valid1_o, div_start_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset got stall=%b valid=%b%b start=%b want 0", stallreq0_o, valid0_o, valid1_o, div_start_o);
        end
    endtask

    task automatic test_single_signed();
        int   stalls = 0;
        int   starts = 0;
        bit   seen   = 0;
        exp_t e;
        to_drive();
        set_req0(1'b1, 32'hFFFF_FFF9, 32'h2);
        exp_q.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFD});
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (stallreq0_o) stalls++;
            if (div_start_o) begin
                starts++;
                n_vec++;
                if ({div_signed_o, div_opdata1_o, div_opdata2_o} !== {1'b1, 32'hFFFF_FFF9, 32'h2}) begin
                    n_bad++;
                    $display("FAIL single_start_ops got %b/%h/%h want 1/fffffff9/00000002", div_signed_o, div_opdata1_o, div_opdata2_o);
                end
            end
            if (valid0_o) begin
                seen = 1;
                e = exp_q.pop_front();
                n_vec++;
                if (res0_o !== e.res || valid1_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_res0 got %h valid1=%b want %h valid1=0", res0_o, valid1_o, e.res);
                end
            end
            to_drive();
        end
        req0_i = 1'b0;
        n_vec++;
        if (!seen) begin n_bad++; $display("FAIL single_timeout got no valid0 want valid0"); end
        n_vec++;
        if (stalls != 6 || starts != 1) begin
            n_bad++;
            $display("FAIL single_stall_start got stalls=%0d starts=%0d want 6 and 1", stalls, starts);
        end
        @(negedge clk);
        n_vec++;
        if (valid0_o !== 1'b0 || stallreq0_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_valid_pulse got valid0=%b stall=%b want 0 0", valid0_o, stallreq0_o);
        end
    endtask

    task automatic test_dual();
        int          stalls = 0;
        int          starts = 0;
        bit          seen   = 0;
        logic [31:0] st_a [2];
        logic [31:0] st_b [2];
        exp_t        e;
        to_drive();
        set_req0(1'b0, 32'd100, 32'd7);
        req1_i = 1'b1; signed1_i = 1'b0; opa1_i = 32'd9; opb1_i = 32'd3;
        exp_q.push_back('{0, {32'd2, 32'd14}});
        exp_q.push_back('{1, {32'd0, 32'd3}});
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (stallreq1_o) stalls++;
            if (div_start_o) begin
                if (starts < 2) begin st_a[starts] = div_opdata1_o; st_b[starts] = div_opdata2_o; end
                starts++;
            end
            if (valid0_o || valid1_o) begin
                seen = 1;
                n_vec++;
                if (valid0_o !== 1'b1 || valid1_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL dual_valid_same_cycle got %b%b want 11", valid1_o, valid0_o);
                end
                e = exp_q.pop_front();
                n_vec++;
                if (res0_o !== e.res) begin n_bad++; $display("FAIL dual_res0 got %h want %h", res0_o, e.res); end
                e = exp_q.pop_front();
                n_vec++;
                if (res1_o !== e.res) begin n_bad++; $display("FAIL dual_res1 got %h want %h", res1_o, e.res); end
            end
            to_drive();
        end
        req0_i = 1'b0;
        req1_i = 1'b0;
        n_vec++;
        if (!seen) begin n_bad++; $display("FAIL dual_timeout got no valid want valid"); end
        n_vec++;
        if (stalls != 11 || starts != 2) begin
            n_bad++;
            $display("FAIL dual_stall_start got stalls=%0d starts=%0d want 11 and 2", stalls, starts);
        end else begin
            n_vec++;
            if ({st_a[0], st_b[0], st_a[1], st_b[1]} !== {32'd100, 32'd7, 32'd9, 32'd3}) begin
                n_bad++;
                $display("FAIL dual_order got %0d/%0d then %0d/%0d want 100/7 then 9/3", st_a[0], st_b[0], st_a[1], st_b[1]);
            end
        end
    endtask

    task automatic test_zero_div();
        int   starts = 0;
        int   when   = -1;
        exp_t e;
        to_drive();
        req1_i = 1'b1; signed1_i = 1'b1; opa1_i = 32'h1234_5678; opb1_i = 32'h0;
        exp_q.push_back('{1, {32'h1234_5678, 32'h0}});
        for (int c = 0; c < 10 && when < 0; c++) begin
            @(negedge clk);
            if (div_start_o) starts++;
            if (valid1_o) begin
                when = c;
                e = exp_q.pop_front();
                n_vec++;
                if (res1_o !== e.res || valid0_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL zero_res1 got %h valid0=%b want %h valid0=0", res1_o, valid0_o, e.res);
                end
            end
            to_drive();
        end
        req1_i = 1'b0;
        n_vec++;
        if (when < 0 || when > 2 || starts != 0) begin
            n_bad++;
            $display("FAIL zero_latency got done_cycle=%0d starts=%0d want <=2 and 0", when, starts);
        end
    endtask

    task automatic test_flush();
        bit st      = 0;
        int annuls  = 0;
        int strays  = 0;
        to_drive();
        set_req0(1'b0, 32'd50, 32'd5);
        for (int c = 0; c < 10 && !st; c++) begin
            @(negedge clk);
            if (div_start_o) st = 1;
            to_drive();
        end
        to_drive();
        flush_i = 1'b1;
        req0_i  = 1'b0;
        @(negedge clk);
        n_vec++;
        if (div_annul_o !== 1'b1 || stallreq0_o !== 1'b0 || valid0_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_cycle got annul=%b stall=%b valid=%b want 1 0 0", div_annul_o, stallreq0_o, valid0_o);
        end
        to_drive();
        flush_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (div_annul_o) annuls++;
            if (valid0_o || valid1_o || div_start_o || stallreq0_o) strays++;
            to_drive();
        end
        n_vec++;
        if (annuls != 0 || strays != 0) begin
            n_bad++;
            $display("FAIL flush_after got annuls=%0d activity=%0d want 0 0", annuls, strays);
        end
    endtask

    task automatic test_done_stall();
        bit   seen   = 0;
        int   starts = 0;
        exp_t e;
        to_drive();
        set_req0(1'b0, 32'd1000, 32'd10);
        stall_i = 1'b1;
        exp_q.push_back('{0, {32'd0, 32'd100}});
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (valid0_o) seen = 1;
            else to_drive();
        end
        n_vec++;
        if (!seen) begin n_bad++; $display("FAIL hold_timeout got no valid0 want valid0"); end
        for (int k = 1; k <= 3; k++) begin
            to_drive();
            if (k == 3) stall_i = 1'b0;
            @(negedge clk);
            if (div_start_o) starts++;
            n_vec++;
            if (valid0_o !== 1'b1 || res0_o !== 64'd100) begin
                n_bad++;
                $display("FAIL hold_stable got valid0=%b res0=%h want 1 %h", valid0_o, res0_o, 64'd100);
            end
        end
        e = exp_q.pop_front();
        n_vec++;
        if (res0_o !== e.res) begin n_bad++; $display("FAIL hold_res0 got %h want %h", res0_o, e.res); end
        to_drive();
        req0_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (valid0_o !== 1'b0 || starts != 0 || div_start_o !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release got valid0=%b starts=%0d want 0 0", valid0_o, starts);
        end
    endtask

    task automatic test_reset_mid_run();
        bit   st   = 0;
        bit   seen = 0;
        exp_t e;
        to_drive();
        set_req0(1'b0, 32'd77, 32'd7);
        for (int c = 0; c < 10 && !st; c++) begin
            @(negedge clk);
            if (div_start_o) st = 1;
            to_drive();
        end
        rst    = 1'b0;
        req0_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (div_annul_o !== 1'b0) begin n_bad++; $display("FAIL rst_no_annul got %b want 0", div_annul_o); end
        to_drive();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({div_start_o, div_annul_o, stallreq0_o, stallreq1_o, valid0_o, valid1_o, res0_o, res1_o} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs got stall=%b valid=%b%b res0=%h res1=%h want all 0",
                     stallreq0_o, valid0_o, valid1_o, res0_o, res1_o);
        end
        to_drive();
        set_req0(1'b0, 32'd77, 32'd7);
        exp_q.push_back('{0, {32'd0, 32'd11}});
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (valid0_o) begin
                seen = 1;
                e = exp_q.pop_front();
                n_vec++;
                if (res0_o !== e.res) begin n_bad++; $display("FAIL rst_fresh_res0 got %h want %h", res0_o, e.res); end
            end
            to_drive();
        end
        req0_i = 1'b0;
        n_vec++;
        if (!seen) begin n_bad++; $display("FAIL rst_fresh_timeout got no valid0 want valid0"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        req0_i = 1'b0; signed0_i = 1'b0; opa0_i = '0; opb0_i = '0;
        req1_i = 1'b0; signed1_i = 1'b0; opa1_i = '0; opb1_i = '0;
        test_reset();
        test_single_signed();
        test_dual();
        test_zero_div();
        test_flush();
        test_done_stall();
        test_reset_mid_run();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
